// File: rtl/rcon_pkg.sv
// Shared definitions for the AES round-constant sequencer: key-length codes,
// round counts, reverse-order seeds and the FSM state type.
package rcon_pkg;

    localparam logic [1:0] KEY_LEN_128     = 2'd0;
    localparam logic [1:0] KEY_LEN_192     = 2'd1;
    localparam logic [1:0] KEY_LEN_256     = 2'd2;
    localparam logic [1:0] KEY_LEN_ILLEGAL = 2'd3;

    localparam logic [3:0] N_128 = 4'd10;
    localparam logic [3:0] N_192 = 4'd8;
    localparam logic [3:0] N_256 = 4'd7;

    // Last Rcon of each forward sequence, used as the seed when running in reverse.
    localparam logic [7:0] INV_SEED_128 = 8'h36;
    localparam logic [7:0] INV_SEED_192 = 8'h80;
    localparam logic [7:0] INV_SEED_256 = 8'h40;

    localparam logic [7:0] POLY_DEFAULT = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [3:0] rcon_count(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_128: rcon_count = N_128;
            KEY_LEN_192: rcon_count = N_192;
            KEY_LEN_256: rcon_count = N_256;
            default:     rcon_count = 4'd0;
        endcase
    endfunction

    function automatic logic [7:0] inv_seed(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_128: inv_seed = INV_SEED_128;
            KEY_LEN_192: inv_seed = INV_SEED_192;
            KEY_LEN_256: inv_seed = INV_SEED_256;
            default:     inv_seed = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/rcon_sequencer_if.sv
// Valid/ready stream carrying round constants and their index toward the
// key-expansion datapath.
interface rcon_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4
);
    logic [WIDTH-1:0] rcon;
    logic [IDX_W-1:0] rcon_idx;
    logic             rcon_valid;
    logic             rcon_ready;
    logic             rcon_last;

    modport master (
        output rcon, rcon_idx, rcon_valid, rcon_last,
        input  rcon_ready
    );

    modport slave (
        input  rcon, rcon_idx, rcon_valid, rcon_last,
        output rcon_ready
    );
endinterface

// File: rtl/gf_xtime_step.sv
// One GF(2^8) multiply-by-x (dir=0) or divide-by-x (dir=1) step; purely
// combinational so MixColumns logic can share it.
module gf_xtime_step
    import rcon_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(POLY_DEFAULT)
) (
    input  logic [WIDTH-1:0] a,
    input  logic             dir,
    output logic [WIDTH-1:0] y
);
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] fwd;
    logic [WIDTH-1:0] inv;

    assign fwd = {a[WIDTH-2:0], 1'b0} ^ (a[WIDTH-1] ? POLY : '0);
    // An odd value had the reduction applied on the way up; undo it and restore bit 7.
    assign inv = a[0] ? (((a ^ POLY) >> 1) | MSB) : (a >> 1);
    assign y   = dir ? inv : fwd;
endmodule

// File: rtl/rcon_sequencer.sv
// Generates the AES Rcon sequence in forward or reverse order, one value per
// accepted stream transfer.
//
// state | meaning
// IDLE  | waiting for start; err pulses on an illegal key length
// RUN   | presenting rcon; advances on each valid&ready transfer
// DONE  | one cycle after the last transfer; done pulses here
module rcon_sequencer
    import rcon_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(POLY_DEFAULT),
    parameter int               IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          key_len,
    input  logic                inverse,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                err,
    rcon_sequencer_if.master    rcon_if
);
    localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

    state_t           state_q;
    logic [IDX_W-1:0] n_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_next;
    logic [IDX_W-1:0] seed_n;
    logic [WIDTH-1:0] rcon_q;
    logic [WIDTH-1:0] rcon_step;
    logic             inv_q;
    logic             valid_q;
    logic             last_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             xfer;
    logic             last_next;

    gf_xtime_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_step (
        .a   (rcon_q),
        .dir (inv_q),
        .y   (rcon_step)
    );

    assign seed_n    = IDX_W'(rcon_count(key_len));
    assign xfer      = valid_q & rcon_if.rcon_ready;
    assign idx_next  = inv_q ? (idx_q - ONE) : (idx_q + ONE);
    assign last_next = inv_q ? (idx_next == '0) : (idx_next == (n_q - ONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            rcon_q  <= '0;
            inv_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (key_len == KEY_LEN_ILLEGAL) begin
                            err_q <= 1'b1;
                        end else begin
                            n_q     <= seed_n;
                            inv_q   <= inverse;
                            rcon_q  <= inverse ? WIDTH'(inv_seed(key_len)) : WIDTH'(1);
                            idx_q   <= inverse ? (seed_n - ONE) : '0;
                            valid_q <= 1'b1;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (xfer) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            rcon_q <= rcon_step;
                            idx_q  <= idx_next;
                            last_q <= last_next;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rcon_if.rcon       = rcon_q;
    assign rcon_if.rcon_idx   = idx_q;
    assign rcon_if.rcon_valid = valid_q;
    assign rcon_if.rcon_last  = last_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign err                = err_q;
endmodule

// File: tb/tb_rcon_sequencer.sv
// Directed bench for rcon_sequencer: a per-cycle vector table plus a
// hand-written reset-during-run sequence.
module tb_rcon_sequencer;

    typedef struct {
        logic       s;
        logic [1:0] kl;
        logic       inv;
        logic       ab;
        logic       rdy;
        logic       e_valid;
        logic [7:0] e_rcon;
        logic [3:0] e_idx;
        logic       e_last;
        logic       e_busy;
        logic       e_done;
        logic       e_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] key_len;
    logic       inverse;
    logic       abort;
    logic       busy;
    logic       done;
    logic       err;

    int n_applied = 0;
    int n_miss    = 0;

    vec_t       vecs[$];
    logic [7:0] fwd [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                             8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    rcon_sequencer_if #(.WIDTH(8), .IDX_W(4)) rif ();

    rcon_sequencer #(.WIDTH(8), .POLY(8'h1B), .IDX_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .key_len (key_len),
        .inverse (inverse),
        .abort   (abort),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .rcon_if (rif.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic v(input logic s, input logic [1:0] kl, input logic inv, input logic ab,
                     input logic rdy, input logic ev, input logic [7:0] er, input logic [3:0] ei,
                     input logic el, input logic eb, input logic ed, input logic ee);
        vecs.push_back('{s, kl, inv, ab, rdy, ev, er, ei, el, eb, ed, ee});
    endtask

    task automatic drive(input logic s, input logic [1:0] kl, input logic inv, input logic ab, input logic rdy);
        start          = s;
        key_len        = kl;
        inverse        = inv;
        abort          = ab;
        rif.rcon_ready = rdy;
    endtask

    initial begin
        // Forward AES-128; a start mid-run must be ignored.
        v(1, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++)
            v(k == 2, 0, 0, 0, 1, 1, fwd[k], 4'(k), k == 9, 1, 0, 0);
        v(0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 1, 1, 0);
        v(0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        // Reverse AES-128.
        v(1, 0, 1, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++)
            v(0, 0, 1, 0, 1, 1, fwd[9-k], 4'(9-k), k == 9, 1, 0, 0);
        v(0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 1, 1, 0);
        v(0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        // Reverse AES-256 with ready alternating 0/1.
        v(1, 2, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) begin
            v(0, 2, 1, 0, 0, 1, fwd[6-k], 4'(6-k), k == 6, 1, 0, 0);
            v(0, 2, 1, 0, 1, 1, fwd[6-k], 4'(6-k), k == 6, 1, 0, 0);
        end
        v(0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 1, 1, 0);
        v(0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        // Forward AES-192, then an illegal key length.
        v(1, 1, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            v(0, 1, 0, 0, 1, 1, fwd[k], 4'(k), k == 7, 1, 0, 0);
        v(0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 1, 1, 0);
        v(1, 3, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 1);
        v(0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        // Abort after the third transfer, with a transfer offered in the same cycle.
        v(1, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            v(0, 0, 0, 0, 1, 1, fwd[k], 4'(k), 0, 1, 0, 0);
        v(0, 0, 0, 1, 1, 1, 8'h08, 3, 0, 1, 0, 0);
        // Start and abort together in IDLE: start wins.
        v(1, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        v(0, 0, 0, 1, 0, 1, 8'h01, 0, 0, 1, 0, 0);
        v(0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("reset_valid", -1, 8'(rif.rcon_valid), 8'h00);
        chk("reset_rcon",  -1, rif.rcon, 8'h00);
        chk("reset_idx",   -1, 8'(rif.rcon_idx), 8'h00);
        chk("reset_busy",  -1, 8'(busy), 8'h00);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            chk("valid", i, 8'(rif.rcon_valid), 8'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                chk("rcon", i, rif.rcon, vecs[i].e_rcon);
                chk("idx",  i, 8'(rif.rcon_idx), 8'(vecs[i].e_idx));
            end
            chk("last", i, 8'(rif.rcon_last), 8'(vecs[i].e_last));
            chk("busy", i, 8'(busy), 8'(vecs[i].e_busy));
            chk("done", i, 8'(done), 8'(vecs[i].e_done));
            chk("err",  i, 8'(err),  8'(vecs[i].e_err));
            drive(vecs[i].s, vecs[i].kl, vecs[i].inv, vecs[i].ab, vecs[i].rdy);
        end

        // Synchronous reset while stalled in RUN, with start held high.
        @(negedge clk);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_run_valid", -2, 8'(rif.rcon_valid), 8'h01);
        chk("rst_run_rcon",  -2, rif.rcon, 8'h01);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_hold_rcon", -3, rif.rcon, 8'h01);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_valid", -4, 8'(rif.rcon_valid), 8'h00);
        chk("rst_rcon",  -4, rif.rcon, 8'h00);
        chk("rst_idx",   -4, 8'(rif.rcon_idx), 8'h00);
        chk("rst_last",  -4, 8'(rif.rcon_last), 8'h00);
        chk("rst_busy",  -4, 8'(busy), 8'h00);
        chk("rst_done",  -4, 8'(done), 8'h00);
        chk("rst_err",   -4, 8'(err), 8'h00);
        rst = 1'b0;
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        chk("post_rst_busy", -5, 8'(busy), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule

// File: doc/rcon_sequencer.md
Name: rcon_sequencer

Overview:
Sequential AES round-constant generator; successor to the fixed 10-entry Rcon lookup table. It produces the Rcon sequence for AES-128/192/256 in forward order (encryption key expansion) or reverse order (on-the-fly decryption key schedule). Values are computed with GF(2^8) xtime or inverse-xtime steps instead of being held in a table. Output uses a valid/ready stream toward the key-expansion datapath.

Parameters:
WIDTH, 8, field width in bits; must equal 8 for AES.
POLY, 8'h1B, low byte of the reduction polynomial (x^8+x^4+x^3+x+1).
IDX_W, 4, width of the round-index output.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle request; sampled only in IDLE.
key_len  in  2  0=AES-128 (10 Rcons), 1=AES-192 (8), 2=AES-256 (7), 3=illegal.
inverse  in  1  0=forward order, 1=reverse order; sampled with start.
abort  in  1  synchronous flush of the current run.
rcon  out  WIDTH  current round constant.
rcon_idx  out  IDX_W  Rcon index 0..N-1 of the current value.
rcon_valid  out  1  rcon/rcon_idx/rcon_last are valid.
rcon_ready  in  1  consumer accepts when rcon_valid and rcon_ready are both 1.
rcon_last  out  1  current value is the final one of the sequence.
busy  out  1  high in RUN and DONE.
done  out  1  one-cycle pulse after the last transfer.
err  out  1  one-cycle pulse when start is given with key_len=3.

Behaviour:
- Reset: all outputs 0 (rcon=8'h00, rcon_idx=0); FSM returns to IDLE; this also applies mid-run.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1, key_len legal:
  - Latch N (10/8/7) and the direction; go to RUN.
  - Forward seed: rcon=8'h01, idx=0.
  - Inverse seed: rcon=36/80/40 for key_len 0/1/2, idx=N-1.
  - rcon_valid=1 in the next cycle (one-cycle latency).
- IDLE, start=1, key_len=3: err=1 for one cycle, remain in IDLE.
- RUN, on a transfer (valid & ready):
  - Forward: rcon <= xtime(rcon) = (rcon<<1) ^ (rcon[7] ? POLY : 0); idx+1.
  - Inverse: rcon <= rcon[0] ? (((rcon ^ POLY) >> 1) | 8'h80) : (rcon >> 1); idx-1.
  - The new value is valid in the following cycle; back-to-back transfers give one value per cycle.
- Backpressure: while rcon_valid=1 and rcon_ready=0, rcon, rcon_idx and rcon_last hold stable and rcon_valid stays 1.
- rcon_last = RUN and (forward ? idx==N-1 : idx==0).
- Transfer while rcon_last=1: go to DONE. In the next cycle rcon_valid=0 and done=1; then return to IDLE.
- start outside IDLE is ignored; no queuing.
- abort in RUN or DONE: go to IDLE next cycle, rcon_valid=0, no done pulse. abort has priority over a simultaneous transfer.
- abort and start together in IDLE: start wins, abort ignored.
- rcon and rcon_idx hold their last value when not valid; consumers must not rely on them then.
- All arithmetic is modulo 2^WIDTH; the index never wraps because the FSM leaves RUN at the last element.

Decomposition:
- Package rcon_pkg holds:
  - key_len encodings and the N count per key length.
  - Inverse seed constants 8'h36, 8'h80, 8'h40.
  - The FSM state enum.
  - Default POLY.
- Sub-module gf_xtime_step (WIDTH, POLY): combinational; inputs a and dir; output one forward or inverse xtime step. It is reused by the MixColumns blocks.

Test Plan:
- key_len=0, inverse=0, ready=1, start pulse -> valid from the next cycle; rcon 01,02,04,08,10,20,40,80,1B,36 on 10 consecutive cycles; idx 0..9; last only at 36; done one cycle later.
- key_len=0, inverse=1 -> 36,1B,80,40,20,10,08,04,02,01; idx 9..0; last at 01.
- key_len=2, inverse=1, ready toggled 1/0 each cycle -> 40,20,10,08,04,02,01, each held while ready=0; exactly 7 transfers; done once.
- key_len=1, inverse=0 -> 01..80 (8 values); then key_len=3 start -> err pulse, busy stays 0, no valid.
- Mid-run abort after 3rd transfer (forward 128) -> valid drops next cycle, no done; a new start then begins again at 01.
- Reset asserted during RUN with ready=0 -> all outputs 0 next cycle; start is ignored while busy (no restart observed).
